// File: rtl/insn_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : insn_sequencer_pkg
// Brief   : Opcodes, ALU mode/flag indices, FSM encodings and operand selects
//           shared by the instruction sequencer and its decoder.
// Rev     : 1.0  initial release
// ============================================================================
package insn_sequencer_pkg;

    localparam int ALU_MODE_COUNT = 8;
    localparam logic [2:0] ALU_MODE_ADD      = 3'd0;
    localparam logic [2:0] ALU_MODE_SHIFT    = 3'd1;
    localparam logic [2:0] ALU_MODE_NOT      = 3'd2;
    localparam logic [2:0] ALU_MODE_AND      = 3'd3;
    localparam logic [2:0] ALU_MODE_OR       = 3'd4;
    localparam logic [2:0] ALU_MODE_XOR      = 3'd5;
    localparam logic [2:0] ALU_MODE_BYPASS_A = 3'd6;
    localparam logic [2:0] ALU_MODE_BYPASS_B = 3'd7;

    localparam int BC_FLAG_COUNT = 2;
    localparam int BC_FLAG_EQ    = 0;
    localparam int BC_FLAG_GT    = 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SH   = 4'h2;
    localparam logic [3:0] OP_SHI  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BGT  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    typedef enum logic [1:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_HALT   = ST_HALT
    } state_t;

    localparam logic ASEL_ACC = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_REG = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    function automatic logic [ALU_MODE_COUNT-1:0] alu_onehot(input logic [2:0] idx);
        logic [ALU_MODE_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/insn_sequencer_decoder.sv
`default_nettype none
// ============================================================================
// Module  : insn_decoder
// Brief   : Combinational opcode/operand decode into ALU controls and strobes.
// Rev     : 1.0  initial release
// ============================================================================
module insn_decoder
    import insn_sequencer_pkg::*;
#(
    parameter int BIT_COUNT = 8
) (
    input  logic [3:0]                i_opcode,
    input  logic [3:0]                i_opnd,
    output logic [ALU_MODE_COUNT-1:0] o_alu_mode,
    output logic                      o_a_sel,
    output logic                      o_b_sel,
    output logic [2:0]                o_reg_idx,
    output logic [BIT_COUNT-1:0]      o_imm_ext,
    output logic                      o_acc_wr,
    output logic                      o_reg_wr,
    output logic                      o_is_branch,
    output logic                      o_is_halt
);

    always_comb begin
        o_alu_mode  = '0;
        o_a_sel     = ASEL_ACC;
        o_b_sel     = BSEL_REG;
        // Index 7 is not a real register; it aliases x0.
        o_reg_idx   = (i_opnd[2:0] == 3'd7) ? 3'd0 : i_opnd[2:0];
        o_imm_ext   = {{(BIT_COUNT-4){1'b0}}, i_opnd};
        o_acc_wr    = 1'b0;
        o_reg_wr    = 1'b0;
        o_is_branch = 1'b0;
        o_is_halt   = 1'b0;
        case (i_opcode)
            OP_ADD:  begin o_alu_mode = alu_onehot(ALU_MODE_ADD);   o_acc_wr = 1'b1; end
            OP_ADDI: begin o_alu_mode = alu_onehot(ALU_MODE_ADD);   o_b_sel = BSEL_IMM; o_acc_wr = 1'b1; end
            OP_SH:   begin o_alu_mode = alu_onehot(ALU_MODE_SHIFT); o_acc_wr = 1'b1; end
            OP_SHI:  begin o_alu_mode = alu_onehot(ALU_MODE_SHIFT); o_b_sel = BSEL_IMM; o_acc_wr = 1'b1; end
            OP_NOT:  begin o_alu_mode = alu_onehot(ALU_MODE_NOT);   o_acc_wr = 1'b1; end
            OP_AND:  begin o_alu_mode = alu_onehot(ALU_MODE_AND);   o_acc_wr = 1'b1; end
            OP_OR:   begin o_alu_mode = alu_onehot(ALU_MODE_OR);    o_acc_wr = 1'b1; end
            OP_XOR:  begin o_alu_mode = alu_onehot(ALU_MODE_XOR);   o_acc_wr = 1'b1; end
            OP_LD:   begin o_alu_mode = alu_onehot(ALU_MODE_BYPASS_B); o_acc_wr = 1'b1; end
            OP_ST:   begin o_alu_mode = alu_onehot(ALU_MODE_BYPASS_A); o_reg_wr = 1'b1; end
            OP_LI:   begin o_alu_mode = alu_onehot(ALU_MODE_BYPASS_B); o_b_sel = BSEL_IMM; o_acc_wr = 1'b1; end
            OP_BEQ, OP_BGT, OP_JMP: begin
                // Target = own address + signed offset, computed by the ALU.
                o_alu_mode  = alu_onehot(ALU_MODE_ADD);
                o_a_sel     = ASEL_PC;
                o_b_sel     = BSEL_IMM;
                o_imm_ext   = {{(BIT_COUNT-4){i_opnd[3]}}, i_opnd};
                o_is_branch = 1'b1;
                if (i_opcode != OP_JMP) begin
                    o_reg_idx = 3'd0;
                end
            end
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/insn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : insn_sequencer
// Brief   : Fetch/decode/execute sequencer owning the PC, driving the ALU.
// Rev     : 1.0  initial release
// ============================================================================
module insn_sequencer
    import insn_sequencer_pkg::*;
#(
    parameter int                 BIT_COUNT = 8,
    parameter logic [BIT_COUNT-1:0] RESET_PC  = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req,
    output logic [BIT_COUNT-1:0]      mem_addr,
    input  logic [BIT_COUNT-1:0]      mem_rdata,
    input  logic                      mem_ack,
    input  logic [BIT_COUNT-1:0]      alu_c,
    input  logic [BC_FLAG_COUNT-1:0]  bc_flags,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      a_sel,
    output logic                      b_sel,
    output logic [2:0]                reg_idx,
    output logic [BIT_COUNT-1:0]      imm_ext,
    output logic                      acc_we,
    output logic                      reg_we,
    output logic [BIT_COUNT-1:0]      pc,
    output logic                      halted
);

    localparam logic [BIT_COUNT-1:0] c_one = {{(BIT_COUNT-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_nxt;

    logic [BIT_COUNT-1:0]      r_pc;
    logic                      r_mem_req;
    logic [ALU_MODE_COUNT-1:0] r_alu_mode;
    logic                      r_a_sel;
    logic                      r_b_sel;
    logic [2:0]                r_reg_idx;
    logic [BIT_COUNT-1:0]      r_imm_ext;
    logic                      r_acc_we;
    logic                      r_reg_we;
    logic                      r_halted;
    logic                      r_acc_wr;
    logic                      r_reg_wr;
    logic                      r_is_branch;
    logic                      r_is_halt;
    logic [3:0]                r_op;

    logic [ALU_MODE_COUNT-1:0] w_dec_mode;
    logic                      w_dec_a_sel;
    logic                      w_dec_b_sel;
    logic [2:0]                w_dec_reg_idx;
    logic [BIT_COUNT-1:0]      w_dec_imm;
    logic                      w_dec_acc_wr;
    logic                      w_dec_reg_wr;
    logic                      w_dec_is_branch;
    logic                      w_dec_is_halt;
    logic                      w_fetch_done;
    logic                      w_taken;

    insn_decoder #(
        .BIT_COUNT (BIT_COUNT)
    ) u_decoder (
        .i_opcode    (mem_rdata[7:4]),
        .i_opnd      (mem_rdata[3:0]),
        .o_alu_mode  (w_dec_mode),
        .o_a_sel     (w_dec_a_sel),
        .o_b_sel     (w_dec_b_sel),
        .o_reg_idx   (w_dec_reg_idx),
        .o_imm_ext   (w_dec_imm),
        .o_acc_wr    (w_dec_acc_wr),
        .o_reg_wr    (w_dec_reg_wr),
        .o_is_branch (w_dec_is_branch),
        .o_is_halt   (w_dec_is_halt)
    );

    // An ack only counts while our request is actually on the bus.
    assign w_fetch_done = (r_state == S_FETCH) && r_mem_req && mem_ack;

    assign w_taken = r_is_branch &&
                     ((r_op == OP_JMP) ||
                      ((r_op == OP_BEQ) && bc_flags[BC_FLAG_EQ]) ||
                      ((r_op == OP_BGT) && bc_flags[BC_FLAG_GT]));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (w_fetch_done) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = r_is_halt ? S_HALT : S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_mem_req   <= 1'b0;
            r_alu_mode  <= '0;
            r_a_sel     <= 1'b0;
            r_b_sel     <= 1'b0;
            r_reg_idx   <= 3'd0;
            r_imm_ext   <= '0;
            r_acc_we    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_halted    <= 1'b0;
            r_acc_wr    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_halt   <= 1'b0;
            r_op        <= 4'h0;
        end else begin
            r_mem_req <= (w_state_nxt == S_FETCH);
            case (r_state)
                S_FETCH: begin
                    // Decode straight off the bus so controls are valid during DECODE.
                    if (w_fetch_done) begin
                        r_op        <= mem_rdata[7:4];
                        r_alu_mode  <= w_dec_mode;
                        r_a_sel     <= w_dec_a_sel;
                        r_b_sel     <= w_dec_b_sel;
                        r_reg_idx   <= w_dec_reg_idx;
                        r_imm_ext   <= w_dec_imm;
                        r_acc_wr    <= w_dec_acc_wr;
                        r_reg_wr    <= w_dec_reg_wr;
                        r_is_branch <= w_dec_is_branch;
                        r_is_halt   <= w_dec_is_halt;
                    end
                end
                S_DECODE: begin
                    r_acc_we <= r_acc_wr;
                    r_reg_we <= r_reg_wr;
                end
                S_EXEC: begin
                    r_pc       <= w_taken ? alu_c : (r_pc + c_one);
                    r_alu_mode <= '0;
                    r_a_sel    <= 1'b0;
                    r_b_sel    <= 1'b0;
                    r_reg_idx  <= 3'd0;
                    r_imm_ext  <= '0;
                    r_acc_we   <= 1'b0;
                    r_reg_we   <= 1'b0;
                    r_halted   <= r_is_halt;
                end
                default: ;
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign alu_mode = r_alu_mode;
    assign a_sel    = r_a_sel;
    assign b_sel    = r_b_sel;
    assign reg_idx  = r_reg_idx;
    assign imm_ext  = r_imm_ext;
    assign acc_we   = r_acc_we;
    assign reg_we   = r_reg_we;
    assign halted   = r_halted;

endmodule
`default_nettype wire
